multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the MIPS datapath. It replaces the single-cycle DECODER and
//  drives the PC, IR, register file, ALU muxes and D_MEM strobes state by state.
//  It waits on a memory-ready handshake, retires one instruction per pass through the FSM,
//  and latches fault conditions (illegal opcode, memory timeout).
// PARAMETERS
//  CNT_W     32  width of retired-instruction counter (wraps modulo 2^CNT_W)
//  WAIT_MAX  15  max cycles a memory state waits for mem_ready before fault
// PORTS
//  clk           in   1      single clock, all state on rising edge
//  rst           in   1      synchronous, active-high reset
//  run           in   1      1 = fetch next instruction; 0 = stop at next instruction boundary
//  opcode        in   6      IR[31:26], stable from DECODE until next FETCH completes
//  funct         in   6      IR[5:0], forwarded to ALU control, unused by FSM
//  alu_zero      in   1      ALU zero flag
//  alu_positive  in   1      ALU result > 0 (signed)
//  mem_ready     in   1      memory completes current access this cycle
//  pc_we         out  1      PC write enable
//  pc_src        out  2      0 = ALU (PC+4), 1 = ALUOut (branch target), 2 = jump {PC[31:28],IR[25:0],2'b00}
//  ir_we         out  1      IR write enable
//  iord          out  1      mem address: 0 = PC, 1 = ALUOut
//  mem_re        out  1      memory read strobe
//  mem_we        out  1      memory write strobe
//  reg_we        out  1      register file write enable
//  reg_dst       out  1      0 = rt, 1 = rd
//  mem_to_reg    out  1      0 = ALUOut, 1 = MDR
//  alu_src_a     out  1      0 = PC, 1 = rs
//  alu_src_b     out  2      0 = rt, 1 = const 4, 2 = sext imm, 3 = sext imm<<2
//  alu_op        out  2      0 = add, 1 = sub, 2 = funct-decoded, 3 = opcode-decoded (I-type)
//  state         out  4      current FSM state, for debug
//  halted        out  1      sticky; opcode 6'h3F retired
//  fault         out  1      sticky; FSM is in ERROR
//  fault_code    out  2      1 = illegal opcode, 2 = memory timeout
//  instr_count   out  CNT_W  number of retired instructions
// BEHAVIOUR
//  Reset: state = IDLE; every output 0; wait counter 0; instr_count 0.
//    Reset takes effect on the next edge even mid-access; a pending mem_we is dropped.
//  Outputs are Moore, decoded from state. Only exception: pc_we in BRANCH also depends on the
//    ALU flags. Strobes not listed for a state are 0.
//  IDLE     : run -> FETCH.
//  FETCH    : mem_re, iord=0, a=0, b=1, op=add.
//             On mem_ready: ir_we = pc_we = 1, pc_src = 0, go to DECODE; otherwise stay.
//  DECODE   : a=0, b=3, op=add (branch target into ALUOut). Branch kind is latched. Next state:
//             R (00) -> EXEC_R; addi/slti/andi/ori (08,0A,0C,0D) -> EXEC_I;
//             lw/sw (23,2B) -> MEM_ADDR; beq/bne/bgtz (04,05,07) -> BRANCH; j (02) -> JUMP;
//             3F -> HALT; anything else -> ERROR with code 1.
//  EXEC_R   : a=1, b=0, op=2 -> WB_ALU (reg_dst=1 latched).
//  EXEC_I   : a=1, b=2, op=3 -> WB_ALU (reg_dst=0).
//  WB_ALU   : reg_we=1, mem_to_reg=0; retire.
//  MEM_ADDR : a=1, b=2, op=add -> MEM_RD (lw) or MEM_WR (sw).
//  MEM_RD   : mem_re, iord=1; on mem_ready -> MEM_WB.
//  MEM_WB   : reg_we, mem_to_reg=1, reg_dst=0; retire.
//  MEM_WR   : mem_we, iord=1, held until mem_ready; retire on mem_ready.
//  BRANCH   : a=1, b=0, op=sub, pc_src=1;
//             pc_we = beq&zero | bne&~zero | bgtz&positive; retire.
//  JUMP     : pc_we=1, pc_src=2; retire.
//  Retire   : instr_count += 1 (wraps); next = run ? FETCH : IDLE.
//             run is sampled only at retire; deasserting it mid-instruction completes that instruction.
//  Wait     : counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle without mem_ready.
//             At WAIT_MAX with no mem_ready -> ERROR, code 2. mem_ready in that same cycle wins.
//  HALT     : halted=1, increments instr_count once on entry; terminal until rst.
//  ERROR    : fault=1, fault_code held; all strobes 0; terminal until rst; run ignored.
//  mem_ready is ignored outside FETCH/MEM_RD/MEM_WR.
// STRUCTURE
//  mips_ctrl_pkg: opcode localparams, state encoding (4b), pc_src / alu_src_b / alu_op / fault codes.
//    This package is shared with ALU_CONTROL.
//  Sub-module mc_opcode_class: combinational opcode -> class (R, I, LS, BR, J, HALT, ILL).
//  Everything else (state register, output decode, wait counter, instr counter) lives in the top module.
// TESTING
//  1. rst=1 with run=1 -> after release: state=IDLE for 1 cycle, then FETCH; all strobes 0 during reset.
//  2. add (op 00), mem_ready=1 -> FETCH, DECODE, EXEC_R, WB_ALU; reg_we=1, reg_dst=1 in cycle 4; instr_count=1.
//  3. lw with mem_ready low 3 cycles in MEM_RD -> mem_re held 4 cycles, then MEM_WB with mem_to_reg=1.
//  4. beq, alu_zero=1 -> pc_we=1, pc_src=1. bne, alu_zero=1 -> pc_we=0. bgtz, alu_positive=1 -> pc_we=1.
//  5. opcode 6'h3B -> ERROR, fault_code=1; sw with mem_ready never high -> ERROR after WAIT_MAX=15 cycles, code 2.
//  6. run dropped during MEM_WR -> write completes, then IDLE. rst asserted in MEM_WR -> mem_we=0 next cycle.
//     opcode 3F -> halted=1, instr_count increments once.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and ALU_CONTROL:
// opcodes, FSM state encoding, mux select codes, fault codes and the
// opcode classes produced by mc_opcode_class.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_ALU   = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WB   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_HALT     = 4'd12,
    ST_ERROR    = 4'd13
  } state_e;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LS, CLS_BR, CLS_J, CLS_HALT, CLS_ILL
  } opclass_e;

  typedef enum logic [1:0] {
    BR_BEQ  = 2'd0,
    BR_BNE  = 2'd1,
    BR_BGTZ = 2'd2
  } brkind_e;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] ALUB_RT       = 2'd0;
  localparam logic [1:0] ALUB_FOUR     = 2'd1;
  localparam logic [1:0] ALUB_SEXT     = 2'd2;
  localparam logic [1:0] ALUB_SEXT_SH2 = 2'd3;

  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_SUB    = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT  = 2'd2;
  localparam logic [1:0] ALUOP_OPCODE = 2'd3;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

  // Where the FSM goes after an instruction retires; run is only looked at here.
  function automatic state_e retire_next(input logic run_now);
    return run_now ? ST_FETCH : ST_IDLE;
  endfunction

  // Branch flavour for a branch-class opcode; bgtz is the fall-through case.
  function automatic brkind_e brkind_of(input logic [5:0] op);
    case (op)
      OP_BEQ:  return BR_BEQ;
      OP_BNE:  return BR_BNE;
      default: return BR_BGTZ;
    endcase
  endfunction

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode classifier: maps IR[31:26] onto the instruction
// class that selects the FSM path out of DECODE.
module mc_opcode_class
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output opclass_e   op_class_o
);

  // Anything not explicitly recognised is reported as illegal.
  always_comb begin
    op_class_o = CLS_ILL;
    case (opcode_i)
      OP_RTYPE:                       op_class_o = CLS_R;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: op_class_o = CLS_I;
      OP_LW, OP_SW:                   op_class_o = CLS_LS;
      OP_BEQ, OP_BNE, OP_BGTZ:        op_class_o = CLS_BR;
      OP_J:                           op_class_o = CLS_J;
      OP_HALT:                        op_class_o = CLS_HALT;
      default:                        op_class_o = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: state register, per-state datapath control
// decode, memory wait/timeout counter and retired-instruction counter.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             alu_positive,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ir_we,
  output logic             iord,
  output logic             mem_re,
  output logic             mem_we,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic [CNT_W-1:0]  count_q;
  logic              count_inc;
  logic              reg_dst_q, reg_dst_d;
  brkind_e           br_kind_q, br_kind_d;
  logic [1:0]        fault_code_q, fault_code_d;
  opclass_e          op_class;
  logic              timeout;
  logic              funct_unused;

  // funct only matters to ALU_CONTROL; the sequencer never looks at it.
  assign funct_unused = ^funct;

  mc_opcode_class u_class (
    .opcode_i   (opcode),
    .op_class_o (op_class)
  );

  // wait_q counts missed mem_ready cycles already spent in this memory state,
  // so the cycle that would make it WAIT_MAX is the last one allowed.
  assign wait_inc = wait_q + WAIT_W'(1);
  assign timeout  = ~mem_ready && (wait_inc == WAIT_LIMIT);

  assign state       = state_q;
  assign halted      = (state_q == ST_HALT);
  assign fault       = (state_q == ST_ERROR);
  assign fault_code  = fault_code_q;
  assign instr_count = count_q;

  // Next-state and control decode; everything defaults to 0 and the wait
  // counter defaults to clear, so it starts at 0 on every memory-state entry.
  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    count_inc    = 1'b0;
    reg_dst_d    = reg_dst_q;
    br_kind_d    = br_kind_q;
    fault_code_d = fault_code_q;
    pc_we        = 1'b0;
    pc_src       = PC_SRC_ALU;
    ir_we        = 1'b0;
    iord         = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    reg_we       = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = ALUB_RT;
    alu_op       = ALUOP_ADD;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_re    = 1'b1;
        alu_src_b = ALUB_FOUR;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d      = ST_ERROR;
          fault_code_d = FAULT_TIMEOUT;
        end else begin
          wait_d = wait_inc;
        end
      end
      ST_DECODE: begin
        alu_src_b = ALUB_SEXT_SH2;
        reg_dst_d = (op_class == CLS_R);
        br_kind_d = brkind_of(opcode);
        case (op_class)
          CLS_R:    state_d = ST_EXEC_R;
          CLS_I:    state_d = ST_EXEC_I;
          CLS_LS:   state_d = ST_MEM_ADDR;
          CLS_BR:   state_d = ST_BRANCH;
          CLS_J:    state_d = ST_JUMP;
          CLS_HALT: begin
            state_d   = ST_HALT;
            count_inc = 1'b1;
          end
          default: begin
            state_d      = ST_ERROR;
            fault_code_d = FAULT_ILLEGAL;
          end
        endcase
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        reg_dst   = reg_dst_q;
        state_d   = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_SEXT;
        alu_op    = ALUOP_OPCODE;
        reg_dst   = reg_dst_q;
        state_d   = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        reg_we    = 1'b1;
        reg_dst   = reg_dst_q;
        count_inc = 1'b1;
        state_d   = retire_next(run);
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_SEXT;
        state_d   = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_re = 1'b1;
        iord   = 1'b1;
        if (mem_ready) begin
          state_d = ST_MEM_WB;
        end else if (timeout) begin
          state_d      = ST_ERROR;
          fault_code_d = FAULT_TIMEOUT;
        end else begin
          wait_d = wait_inc;
        end
      end
      ST_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        count_inc  = 1'b1;
        state_d    = retire_next(run);
      end
      ST_MEM_WR: begin
        mem_we = 1'b1;
        iord   = 1'b1;
        if (mem_ready) begin
          count_inc = 1'b1;
          state_d   = retire_next(run);
        end else if (timeout) begin
          state_d      = ST_ERROR;
          fault_code_d = FAULT_TIMEOUT;
        end else begin
          wait_d = wait_inc;
        end
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PC_SRC_ALUOUT;
        case (br_kind_q)
          BR_BEQ:  pc_we = alu_zero;
          BR_BNE:  pc_we = ~alu_zero;
          BR_BGTZ: pc_we = alu_positive;
          default: pc_we = 1'b0;
        endcase
        count_inc = 1'b1;
        state_d   = retire_next(run);
      end
      ST_JUMP: begin
        pc_we     = 1'b1;
        pc_src    = PC_SRC_JUMP;
        count_inc = 1'b1;
        state_d   = retire_next(run);
      end
      ST_HALT:  state_d = ST_HALT;
      ST_ERROR: state_d = ST_ERROR;
      // Unused encodings fall back to IDLE rather than wedging the sequencer.
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, counters and latched decode information, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      count_q      <= '0;
      reg_dst_q    <= 1'b0;
      br_kind_q    <= BR_BEQ;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      reg_dst_q    <= reg_dst_d;
      br_kind_q    <= br_kind_d;
      fault_code_q <= fault_code_d;
      if (count_inc) count_q <= count_q + CNT_W'(1);
    end
  end

endmodule
